id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
- ID/EX boundary stage, directly downstream of the opcode decoder.
- Registers the decoded control bundle and register indices into EX.
- Detects load-use hazards and inserts bubbles; applies branch/jump flushes from EX.
- Sequences HALT: drains the pipeline, then freezes fetch permanently until reset.
- Drives PC/IF-ID write enables and the IF/ID flush upstream.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED; must be ≥1. Default equals the EX/MEM/WB depth.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoded controls.
- id_aluop  in  2  decoded ALUOp.
- id_mux_final  in  2  decoded writeback-select.
- id_halt  in  1  decoder's haltInsert.
- id_rs1, id_rs2, id_rd  in  REG_W  ID register indices.
- ex_flush  in  1  branch/jump taken, resolved in EX this cycle.
- ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  registered controls.
- ex_aluop, ex_mux_final  out  2 each  registered controls.
- ex_valid  out  1  EX holds a real instruction.
- ex_rs1, ex_rs2, ex_rd  out  REG_W  registered indices.
- pc_write  out  1  combinational PC write enable.
- ifid_write  out  1  combinational IF/ID write enable.
- ifid_flush  out  1  combinational; equals ex_flush.
- load_use_stall  out  1  combinational hazard indicator.
- halted  out  1  registered; 1 in HALTED.

Behaviour:
- Reset (synchronous, wins over everything):
  - All ex_* outputs = 0; ex_valid = 0.
  - state = RUN; drain counter = 0; halted = 0.
- Bubble: all ex_* controls = 0, ex_valid = 0, ex_rs1/ex_rs2/ex_rd = 0.
- load_use (combinational) = state==RUN & id_valid & ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Both rs fields are always compared (conservative); no opcode qualification.
- States: RUN, DRAIN, HALTED (2-bit enum).
- RUN, per-cycle priority (highest first):
  1. ex_flush:
     - Next EX = bubble; pc_write = 1; ifid_write = 1; ifid_flush = 1.
     - id_halt is ignored (halt was on the wrong path); load_use is ignored.
  2. load_use:
     - Next EX = bubble; pc_write = 0; ifid_write = 0.
     - id_halt is not accepted this cycle and is re-evaluated next cycle.
  3. id_valid & id_halt:
     - Next EX = bubble; pc_write = 0; ifid_write = 0.
     - state → DRAIN; counter = DRAIN_CYCLES-1.
  4. Otherwise:
     - EX captures the ID bundle; ex_valid = id_valid.
     - If id_valid = 0, EX takes a bubble.
     - pc_write = 1; ifid_write = 1.
- DRAIN:
  - Each cycle: EX = bubble; pc_write = 0; ifid_write = 0.
  - ex_flush is ignored and ifid_flush is forced to 0 (only older instructions remain, none in EX).
  - load_use_stall = 0.
  - Counter decrements; at counter==0 → HALTED.
  - Exactly DRAIN_CYCLES cycles are spent in DRAIN.
- HALTED:
  - EX = bubble; pc_write = 0; ifid_write = 0; ifid_flush = 0.
  - halted = 1 from the first HALTED cycle.
  - Only reset exits.
- Latency: ID→EX capture is 1 cycle. Enables respond the same cycle (combinational on current state and inputs).
- Reset mid-DRAIN or mid-stall: next cycle is RUN with a bubble in EX; no residual stall.
- Counter width: $clog2(DRAIN_CYCLES)+1 bits; no wrap possible.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - typedef ctrl_bundle_t (packed struct: alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0], mux_final[1:0]).
  - typedef halt_state_e {RUN, DRAIN, HALTED}.
  - Localparams for opcodes R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, HALT (7'b1001100).
- One sub-module, hazard_detect: purely combinational load_use computation, reusable by forwarding logic.
- FSM and the ID/EX register stay in the top module.

Test Plan:
1. Load-use: EX = LW (memread = 1, rd = 5); ID = add with rs1 = 5 → load_use_stall = 1, pc_write = 0, ifid_write = 0; next cycle ex_valid = 0. The following cycle add enters EX with ex_rs1 = 5.
2. No false hazard: EX = LW with rd = 0, ID rs1 = 0 → no stall. EX = LW with rd = 7, ID rs1 = 3 / rs2 = 4 → no stall, bundle captured.
3. Flush priority: ex_flush = 1 with ID = HALT and a simultaneous load-use condition → ifid_flush = 1, pc_write = 1, EX bubble, state stays RUN, halted stays 0.
4. Halt drain: ID = HALT, no flush → pc_write = 0 immediately; exactly 3 bubble cycles (DRAIN_CYCLES = 3); halted = 1 on cycle 4 and stays 1 for 20 more cycles. ex_flush pulses during DRAIN have no effect.
5. Reset mid-DRAIN: assert reset in the 2nd DRAIN cycle → next cycle state RUN, halted = 0, pc_write = 1, all ex_* = 0.
6. Normal flow: 4 back-to-back R-type bundles (e.g. regwrite = 1, aluop = 2'b10, rd = 1..4) → each appears on ex_* exactly 1 cycle later, pc_write = 1 throughout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: decoded control bundle, halt sequencer
// states and the opcode encodings the decoder recognises.
package pipe_ctrl_pkg;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic [1:0] mux_final;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'b1001100;

endpackage

// File: rtl/id_ex_ctrl_stage_hazard_detect.sv
// Combinational load-use hazard detector (module hazard_detect).
// Ports: i_id_valid, i_id_rs1/rs2 (ID), i_ex_valid, i_ex_memread, i_ex_rd (EX); o_load_use.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic             o_load_use
);

    logic w_rd_nz;
    logic w_match;

    // Both source fields are compared even if the ID opcode ignores rs2;
    // a spurious one-cycle stall is cheaper than decoding the opcode here.
    assign w_rd_nz    = (i_ex_rd != '0);
    assign w_match    = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
    assign o_load_use = i_id_valid & i_ex_valid & i_ex_memread
                      & w_rd_nz & w_match;

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control register with load-use bubbles, EX flushes and HALT drain.
// Ports: decoded id_* in, registered ex_* out, pc/ifid enables, halted.
module id_ex_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_alusrc,
    input  logic             id_memtoreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_branch,
    input  logic [1:0]       id_aluop,
    input  logic [1:0]       id_mux_final,
    input  logic             id_halt,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_flush,
    output logic             ex_alusrc,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_branch,
    output logic [1:0]       ex_aluop,
    output logic [1:0]       ex_mux_final,
    output logic             ex_valid,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [REG_W-1:0] ex_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             load_use_stall,
    output logic             halted
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

    halt_state_e  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic         r_halted;
    ctrl_bundle_t r_ctrl;
    logic         r_valid;
    logic [REG_W-1:0] r_rs1;
    logic [REG_W-1:0] r_rs2;
    logic [REG_W-1:0] r_rd;

    ctrl_bundle_t w_id_ctrl;
    logic         w_run;
    logic         w_hazard;
    logic         w_load_use;
    logic         w_pc_write;
    logic         w_capture;
    logic         w_enter_drain;

    assign w_id_ctrl = '{
        alusrc:    id_alusrc,
        memtoreg:  id_memtoreg,
        regwrite:  id_regwrite,
        memread:   id_memread,
        memwrite:  id_memwrite,
        branch:    id_branch,
        aluop:     id_aluop,
        mux_final: id_mux_final
    };

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .i_id_valid   (id_valid),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_ctrl.memread),
        .i_ex_rd      (r_rd),
        .o_load_use   (w_hazard)
    );

    assign w_run      = (r_state == RUN);
    assign w_load_use = w_run & w_hazard;

    // Priority in RUN: flush, then load-use, then halt, then normal capture.
    // Outside RUN nothing advances and EX only ever sees bubbles.
    always_comb begin
        w_pc_write    = 1'b0;
        w_capture     = 1'b0;
        w_enter_drain = 1'b0;
        if (w_run) begin
            if (ex_flush) begin
                w_pc_write = 1'b1;
            end else if (w_load_use) begin
                w_pc_write = 1'b0;
            end else if (id_valid & id_halt) begin
                w_enter_drain = 1'b1;
            end else begin
                w_pc_write = 1'b1;
                w_capture  = id_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
            r_ctrl   <= '0;
            r_valid  <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
        end else begin
            if (w_capture) begin
                r_ctrl  <= w_id_ctrl;
                r_valid <= 1'b1;
                r_rs1   <= id_rs1;
                r_rs2   <= id_rs2;
                r_rd    <= id_rd;
            end else begin
                r_ctrl  <= '0;
                r_valid <= 1'b0;
                r_rs1   <= '0;
                r_rs2   <= '0;
                r_rd    <= '0;
            end
            unique case (r_state)
                RUN: begin
                    if (w_enter_drain) begin
                        r_state <= DRAIN;
                        r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign ex_alusrc      = r_ctrl.alusrc;
    assign ex_memtoreg    = r_ctrl.memtoreg;
    assign ex_regwrite    = r_ctrl.regwrite;
    assign ex_memread     = r_ctrl.memread;
    assign ex_memwrite    = r_ctrl.memwrite;
    assign ex_branch      = r_ctrl.branch;
    assign ex_aluop       = r_ctrl.aluop;
    assign ex_mux_final   = r_ctrl.mux_final;
    assign ex_valid       = r_valid;
    assign ex_rs1         = r_rs1;
    assign ex_rs2         = r_rs2;
    assign ex_rd          = r_rd;
    assign pc_write       = w_pc_write;
    assign ifid_write     = w_pc_write;
    assign ifid_flush     = w_run & ex_flush;
    assign load_use_stall = w_load_use;
    assign halted         = r_halted;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage: vector table for the steady-state
// pipeline, hand-written sequences for flush, halt drain and reset.
module tb_id_ex_ctrl_stage;

    logic       clk;
    logic       reset;
    logic       id_valid, id_alusrc, id_memtoreg, id_regwrite;
    logic       id_memread, id_memwrite, id_branch, id_halt;
    logic [1:0] id_aluop, id_mux_final;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_flush;
    logic       ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
    logic       ex_memwrite, ex_branch, ex_valid;
    logic [1:0] ex_aluop, ex_mux_final;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       pc_write, ifid_write, ifid_flush, load_use_stall, halted;

    int checks;
    int failures;

    id_ex_ctrl_stage #(
        .DRAIN_CYCLES(3),
        .REG_W(5)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_alusrc(id_alusrc),
        .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_aluop(id_aluop),
        .id_mux_final(id_mux_final), .id_halt(id_halt),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_flush(ex_flush),
        .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_mux_final(ex_mux_final),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .load_use_stall(load_use_stall),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       mr;
        logic       rw;
        logic [1:0] aop;
        logic [4:0] rs1, rs2, rd;
        logic       e_pc, e_stall, e_valid, e_rw, e_mr;
        logic [4:0] e_rd, e_rs1;
        logic [1:0] e_aop;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(
        input logic v, input logic mr, input logic rw,
        input logic [1:0] aop,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic e_pc, input logic e_stall, input logic e_valid,
        input logic e_rw, input logic e_mr, input logic [4:0] e_rd,
        input logic [4:0] e_rs1, input logic [1:0] e_aop);
        vec_t t;
        t.v = v; t.mr = mr; t.rw = rw; t.aop = aop;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.e_pc = e_pc; t.e_stall = e_stall; t.e_valid = e_valid;
        t.e_rw = e_rw; t.e_mr = e_mr; t.e_rd = e_rd;
        t.e_rs1 = e_rs1; t.e_aop = e_aop;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    // Loads drive memread/memtoreg/alusrc together; other fields stay 0.
    task automatic drive(input logic v, input logic hlt, input logic fl,
                         input logic rw, input logic mr,
                         input logic [1:0] aop, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v; id_halt = hlt; ex_flush = fl;
        id_regwrite = rw; id_memread = mr; id_memtoreg = mr;
        id_alusrc = mr; id_aluop = aop; id_rs1 = rs1; id_rs2 = rs2;
        id_rd = rd; id_memwrite = 1'b0; id_branch = 1'b0;
        id_mux_final = 2'b00;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        failures = 0;

        //          v  mr rw aop   rs1 rs2 rd  pc st val rw mr rd  rs1 aop
        tbl[0]  = mk(1, 1, 1, 2'b00, 2, 0, 5,  1, 0, 1, 1, 1, 5, 2, 2'b00);
        tbl[1]  = mk(1, 0, 1, 2'b10, 5, 6, 7,  0, 1, 0, 0, 0, 0, 0, 2'b00);
        tbl[2]  = mk(1, 0, 1, 2'b10, 5, 6, 7,  1, 0, 1, 1, 0, 7, 5, 2'b10);
        tbl[3]  = mk(1, 1, 1, 2'b00, 1, 0, 0,  1, 0, 1, 1, 1, 0, 1, 2'b00);
        tbl[4]  = mk(1, 0, 1, 2'b10, 0, 0, 3,  1, 0, 1, 1, 0, 3, 0, 2'b10);
        tbl[5]  = mk(1, 1, 1, 2'b00, 1, 0, 7,  1, 0, 1, 1, 1, 7, 1, 2'b00);
        tbl[6]  = mk(1, 0, 1, 2'b10, 3, 4, 8,  1, 0, 1, 1, 0, 8, 3, 2'b10);
        tbl[7]  = mk(1, 0, 1, 2'b10, 9, 10, 1, 1, 0, 1, 1, 0, 1, 9, 2'b10);
        tbl[8]  = mk(1, 0, 1, 2'b10, 9, 10, 2, 1, 0, 1, 1, 0, 2, 9, 2'b10);
        tbl[9]  = mk(1, 0, 1, 2'b10, 9, 10, 3, 1, 0, 1, 1, 0, 3, 9, 2'b10);
        tbl[10] = mk(1, 0, 1, 2'b10, 9, 10, 4, 1, 0, 1, 1, 0, 4, 9, 2'b10);
        tbl[11] = mk(0, 0, 1, 2'b10, 9, 10, 9, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[12] = mk(1, 1, 1, 2'b00, 2, 0, 4,  1, 0, 1, 1, 1, 4, 2, 2'b00);
        tbl[13] = mk(1, 0, 1, 2'b10, 1, 4, 6,  0, 1, 0, 0, 0, 0, 0, 2'b00);

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_regwrite", 32'(ex_regwrite), 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].v, 1'b0, 1'b0, tbl[i].rw, tbl[i].mr, tbl[i].aop,
                  tbl[i].rs1, tbl[i].rs2, tbl[i].rd);
            #1;
            chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(tbl[i].e_pc));
            chk($sformatf("v%0d_ifid_write", i), 32'(ifid_write), 32'(tbl[i].e_pc));
            chk($sformatf("v%0d_ifid_flush", i), 32'(ifid_flush), 32'd0);
            chk($sformatf("v%0d_stall", i), 32'(load_use_stall), 32'(tbl[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d_ex_rs1", i), 32'(ex_rs1), 32'(tbl[i].e_rs1));
            chk($sformatf("v%0d_ex_regwrite", i), 32'(ex_regwrite), 32'(tbl[i].e_rw));
            chk($sformatf("v%0d_ex_memread", i), 32'(ex_memread), 32'(tbl[i].e_mr));
            chk($sformatf("v%0d_ex_aluop", i), 32'(ex_aluop), 32'(tbl[i].e_aop));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'd0);
        end

        // Flush beats both a pending halt and a load-use hazard.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 5'd0, 5'd5);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd5, 5'd0, 5'd0);
        #1;
        chk("fl_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("fl_pc_write", 32'(pc_write), 32'd1);
        chk("fl_ifid_write", 32'(ifid_write), 32'd1);
        @(posedge clk);
        #1;
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_halted", 32'(halted), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("fl_still_run_pc", 32'(pc_write), 32'd1);

        // Halt drain: three bubble cycles, then halted for good.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        #1;
        chk("h0_pc_write", 32'(pc_write), 32'd0);
        chk("h0_ifid_write", 32'(ifid_write), 32'd0);
        @(posedge clk);
        #1;
        chk("h0_ex_valid", 32'(ex_valid), 32'd0);
        chk("h0_halted", 32'(halted), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, (c == 2), 1'b1, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3);
            #1;
            chk($sformatf("d%0d_pc_write", c), 32'(pc_write), 32'd0);
            chk($sformatf("d%0d_ifid_flush", c), 32'(ifid_flush), 32'd0);
            chk($sformatf("d%0d_stall", c), 32'(load_use_stall), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("d%0d_ex_valid", c), 32'(ex_valid), 32'd0);
            chk($sformatf("d%0d_halted", c), 32'(halted), 32'(c == 3));
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, c[0], 1'b1, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3);
            #1;
            chk($sformatf("hz%0d_halted", c), 32'(halted), 32'd1);
            chk($sformatf("hz%0d_pc_write", c), 32'(pc_write), 32'd0);
            chk($sformatf("hz%0d_ifid_flush", c), 32'(ifid_flush), 32'd0);
            chk($sformatf("hz%0d_ex_valid", c), 32'(ex_valid), 32'd0);
        end

        // Reset in the second DRAIN cycle returns cleanly to RUN.
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        idle();
        #1;
        chk("r_drain1_pc", 32'(pc_write), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("r_halted", 32'(halted), 32'd0);
        chk("r_pc_write", 32'(pc_write), 32'd1);
        chk("r_ex_valid", 32'(ex_valid), 32'd0);
        chk("r_ex_rd", 32'(ex_rd), 32'd0);
        chk("r_ex_memread", 32'(ex_memread), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd3, 5'd4, 5'd9);
        @(posedge clk);
        #1;
        chk("r_capture_valid", 32'(ex_valid), 32'd1);
        chk("r_capture_rd", 32'(ex_rd), 32'd9);
        chk("r_capture_rs2", 32'(ex_rs2), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
